// File: rtl/alu_pkg.sv
// Shared compare opcodes and helpers for the integer compare units.
package alu_pkg;

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b100;
    localparam logic [2:0] OP_GE  = 3'b101;
    localparam logic [2:0] OP_LTU = 3'b110;
    localparam logic [2:0] OP_GEU = 3'b111;

    // Codes 010 and 011 have no compare meaning.
    function automatic logic op_is_legal(input logic [2:0] op);
        return op[2:1] != 2'b01;
    endfunction

    // Pick the result bit for a compare flavour; illegal codes yield 0.
    function automatic logic cmp_select(input logic [2:0] op, input logic eq, input logic lt,
                                        input logic ltu);
        logic r;
        r = 1'b0;
        case (op)
            OP_EQ:   r = eq;
            OP_NE:   r = ~eq;
            OP_LT:   r = lt;
            OP_GE:   r = ~lt;
            OP_LTU:  r = ltu;
            OP_GEU:  r = ~ltu;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_cmp_slice.sv
// Combinational equality / unsigned less-than over one operand slice.
module alu_cmp_slice #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         ltu
);

    assign eq  = (a == b);
    assign ltu = (a < b);

endmodule

// File: rtl/alu_cmp_pipe.sv
// Pipelined RISC-V compare unit (EQ/NE/LT/GE/LTU/GEU) with valid/ready on both sides.
module alu_cmp_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    // Final (output) stage, shared by both pipeline depths.
    logic             last_valid;
    logic             last_res;
    logic             last_err;
    logic [TAG_W-1:0] last_tag;
    logic             last_adv;

    // Output stage may load when empty or when its entry leaves this cycle.
    assign last_adv = ~last_valid | out_ready;

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("alu_cmp_pipe: WIDTH must be even and >= 4");
    end

    if (STAGES == 1) begin : g_one
        logic eq;
        logic ltu;
        logic lt;

        alu_cmp_slice #(.W(WIDTH)) u_slice (.a(rs1), .b(rs2), .eq(eq), .ltu(ltu));

        // Signed order differs from unsigned exactly when the sign bits differ.
        assign lt       = ltu ^ rs1[WIDTH-1] ^ rs2[WIDTH-1];
        assign in_ready = last_adv;

        // Single register stage: whole compare resolved before the flop.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                last_valid <= 1'b0;
                last_res   <= 1'b0;
                last_err   <= 1'b0;
                last_tag   <= '0;
            end else if (last_adv) begin
                last_valid <= in_valid;
                if (in_valid) begin
                    last_res <= cmp_select(op, eq, lt, ltu);
                    last_err <= ~op_is_legal(op);
                    last_tag <= in_tag;
                end
            end
        end
    end else if (STAGES == 2) begin : g_two
        localparam int unsigned H = WIDTH / 2;

        logic             eq_hi, ltu_hi, eq_lo, ltu_lo;
        logic             v1_q, eq_hi_q, ltu_hi_q, eq_lo_q, ltu_lo_q, sa_q, sb_q, err1_q;
        logic [2:0]       op1_q;
        logic [TAG_W-1:0] tag1_q;
        logic             adv1;
        logic             eq, ltu, lt;

        alu_cmp_slice #(.W(H)) u_hi (
            .a  (rs1[WIDTH-1:H]),
            .b  (rs2[WIDTH-1:H]),
            .eq (eq_hi),
            .ltu(ltu_hi)
        );
        alu_cmp_slice #(.W(H)) u_lo (
            .a  (rs1[H-1:0]),
            .b  (rs2[H-1:0]),
            .eq (eq_lo),
            .ltu(ltu_lo)
        );

        assign adv1     = ~v1_q | last_adv;
        assign in_ready = adv1;

        // Upper half decides unless equal, then the lower half decides.
        assign eq  = eq_hi_q & eq_lo_q;
        assign ltu = ltu_hi_q | (eq_hi_q & ltu_lo_q);
        assign lt  = ltu ^ sa_q ^ sb_q;

        // Stage 1: per-half slice results plus everything the combine needs.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v1_q     <= 1'b0;
                eq_hi_q  <= 1'b0;
                ltu_hi_q <= 1'b0;
                eq_lo_q  <= 1'b0;
                ltu_lo_q <= 1'b0;
                sa_q     <= 1'b0;
                sb_q     <= 1'b0;
                err1_q   <= 1'b0;
                op1_q    <= 3'b000;
                tag1_q   <= '0;
            end else if (adv1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    eq_hi_q  <= eq_hi;
                    ltu_hi_q <= ltu_hi;
                    eq_lo_q  <= eq_lo;
                    ltu_lo_q <= ltu_lo;
                    sa_q     <= rs1[WIDTH-1];
                    sb_q     <= rs2[WIDTH-1];
                    err1_q   <= ~op_is_legal(op);
                    op1_q    <= op;
                    tag1_q   <= in_tag;
                end
            end
        end

        // Stage 2: combine halves and select the requested flavour.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                last_valid <= 1'b0;
                last_res   <= 1'b0;
                last_err   <= 1'b0;
                last_tag   <= '0;
            end else if (last_adv) begin
                last_valid <= v1_q;
                if (v1_q) begin
                    last_res <= cmp_select(op1_q, eq, lt, ltu);
                    last_err <= err1_q;
                    last_tag <= tag1_q;
                end
            end
        end
    end else begin : g_bad_stages
        $error("alu_cmp_pipe: STAGES must be 1 or 2");
    end

    assign out_valid = last_valid;
    assign rd        = {{(WIDTH - 1){1'b0}}, last_res};
    assign out_tag   = last_tag;
    assign out_err   = last_err;

endmodule

// File: tb/tb_alu_cmp_pipe.sv
// Bench: drives a STAGES=1 and a STAGES=2 instance in turn, checking against a reference model.
module tb_alu_cmp_pipe;
    import alu_pkg::*;

    typedef struct packed {
        logic        err;
        logic [3:0]  tag;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       in_valid, in_ready, out_valid, out_ready, out_err;
    logic [1:0][2:0]  op;
    logic [1:0][31:0] rs1, rs2, rd;
    logic [1:0][3:0]  in_tag, out_tag;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    alu_cmp_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .op(op[0]),
        .rs1(rs1[0]), .rs2(rs2[0]), .in_tag(in_tag[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .rd(rd[0]), .out_tag(out_tag[0]), .out_err(out_err[0])
    );

    alu_cmp_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .op(op[1]),
        .rs1(rs1[1]), .rs2(rs2[1]), .in_tag(in_tag[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .rd(rd[1]), .out_tag(out_tag[1]), .out_err(out_err[1])
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Returns {err, result bit} straight from the RISC-V compare definitions.
    function automatic logic [1:0] ref_cmp(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        case (o)
            3'b000:  return {1'b0, a == b};
            3'b001:  return {1'b0, a != b};
            3'b100:  return {1'b0, $signed(a) < $signed(b)};
            3'b101:  return {1'b0, $signed(a) >= $signed(b)};
            3'b110:  return {1'b0, a < b};
            3'b111:  return {1'b0, a >= b};
            default: return 2'b10;
        endcase
    endfunction

    // Single op on an idle pipe; called at posedge+1, returns at posedge+1.
    task automatic run_op(input int d, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t, input logic exp_bit,
                          input logic exp_err, input string name);
        int lat;
        bit seen;
        out_ready[d] = 1'b1;
        in_valid[d]  = 1'b1;
        op[d]        = o;
        rs1[d]       = a;
        rs2[d]       = b;
        in_tag[d]    = t;
        @(negedge clk);
        chk({name, ".in_ready"}, 64'(in_ready[d]), 64'd1);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            lat++;
            @(negedge clk);
            if (out_valid[d]) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk({name, ".seen"}, 64'(seen), 64'd1);
        chk({name, ".latency"}, 64'(lat), 64'(d + 1));
        chk({name, ".rd"}, 64'(rd[d]), {63'd0, exp_bit});
        chk({name, ".tag"}, 64'(out_tag[d]), 64'(t));
        chk({name, ".err"}, 64'(out_err[d]), {63'd0, exp_err});
        @(posedge clk); #1;
    endtask

    // Eight random ops with tags 0..7; optional out_ready drop on cycles 3..6.
    task automatic stream(input int d, input bit stall, input string name);
        int          issued, delivered, cyc, not_ready;
        bit          pending, prev_stall;
        logic [31:0] prev_rd;
        logic [3:0]  prev_tag;
        logic        prev_err;
        logic [1:0]  r;
        exp_t        e;
        q.delete();
        issued     = 0;
        delivered  = 0;
        cyc        = 0;
        not_ready  = 0;
        pending    = 1'b0;
        prev_stall = 1'b0;
        prev_rd    = '0;
        prev_tag   = '0;
        prev_err   = 1'b0;
        while (delivered < 8 && cyc < 40) begin
            out_ready[d] = !(stall && cyc >= 3 && cyc <= 6);
            if (issued < 8 && !pending) begin
                op[d]     = 3'($urandom_range(0, 7));
                rs1[d]    = $urandom;
                case ($urandom_range(0, 3))
                    0:       rs2[d] = rs1[d];
                    1:       rs2[d] = {rs1[d][31:16], 16'($urandom)};
                    default: rs2[d] = $urandom;
                endcase
                in_tag[d] = 4'(issued);
                pending   = 1'b1;
            end
            in_valid[d] = pending;
            @(negedge clk);
            if (prev_stall) begin
                chk({name, ".hold_rd"}, 64'(rd[d]), 64'(prev_rd));
                chk({name, ".hold_tag"}, 64'(out_tag[d]), 64'(prev_tag));
                chk({name, ".hold_err"}, 64'(out_err[d]), 64'(prev_err));
            end
            if (!in_ready[d]) not_ready++;
            if (out_valid[d] && out_ready[d]) begin
                chk({name, ".expected_any"}, 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk({name, ".rd"}, 64'(rd[d]), 64'(e.rd));
                    chk({name, ".tag"}, 64'(out_tag[d]), 64'(e.tag));
                    chk({name, ".err"}, 64'(out_err[d]), 64'(e.err));
                    if (!stall) chk({name, ".cycle"}, 64'(cyc), 64'(d + 1 + delivered));
                end
                delivered++;
            end
            prev_stall = out_valid[d] && !out_ready[d];
            prev_rd    = rd[d];
            prev_tag   = out_tag[d];
            prev_err   = out_err[d];
            if (in_valid[d] && in_ready[d]) begin
                r = ref_cmp(op[d], rs1[d], rs2[d]);
                e = '{err: r[1], tag: in_tag[d], rd: {31'd0, r[0]}};
                q.push_back(e);
                issued++;
                pending = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        chk({name, ".delivered"}, 64'(delivered), 64'd8);
        chk({name, ".leftover"}, 64'(q.size()), 64'd0);
        if (stall) chk({name, ".saw_backpressure"}, 64'(not_ready > 0), 64'd1);
        else       chk({name, ".never_blocked"}, 64'(not_ready), 64'd0);
    endtask

    // Reset with work in flight; flushed entries must never surface.
    task automatic reset_flush(input int d, input string name);
        bit seen;
        out_ready[d] = 1'b0;
        in_valid[d]  = 1'b1;
        op[d]        = OP_EQ;
        rs1[d]       = 32'd5;
        rs2[d]       = 32'd5;
        in_tag[d]    = 4'd9;
        @(posedge clk); #1;
        in_tag[d] = 4'd10;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        rst_n       = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk({name, ".out_valid"}, 64'(out_valid[d]), 64'd0);
        chk({name, ".rd"}, 64'(rd[d]), 64'd0);
        chk({name, ".tag"}, 64'(out_tag[d]), 64'd0);
        chk({name, ".err"}, 64'(out_err[d]), 64'd0);
        chk({name, ".in_ready"}, 64'(in_ready[d]), 64'd1);
        out_ready[d] = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid[d]) seen = 1'b1;
        end
        chk({name, ".ghost"}, 64'(seen), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        string p;
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 2'b11;
        op        = '0;
        rs1       = '0;
        rs2       = '0;
        in_tag    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            p = $sformatf("s%0d.reset", d + 1);
            chk({p, ".out_valid"}, 64'(out_valid[d]), 64'd0);
            chk({p, ".rd"}, 64'(rd[d]), 64'd0);
            chk({p, ".tag"}, 64'(out_tag[d]), 64'd0);
            chk({p, ".err"}, 64'(out_err[d]), 64'd0);
            chk({p, ".in_ready"}, 64'(in_ready[d]), 64'd1);
        end
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            p = $sformatf("s%0d.", d + 1);
            run_op(d, OP_LTU, 32'hFFFF_FFFF, 32'd1, 4'd1, 1'b0, 1'b0, {p, "ltu_max"});
            run_op(d, OP_LT,  32'hFFFF_FFFF, 32'd1, 4'd2, 1'b1, 1'b0, {p, "lt_neg1"});
            run_op(d, OP_LT,  32'h8000_0000, 32'h7FFF_FFFF, 4'd3, 1'b1, 1'b0, {p, "sign_lt"});
            run_op(d, OP_GE,  32'h8000_0000, 32'h7FFF_FFFF, 4'd4, 1'b0, 1'b0, {p, "sign_ge"});
            run_op(d, OP_LTU, 32'h8000_0000, 32'h7FFF_FFFF, 4'd5, 1'b0, 1'b0, {p, "sign_ltu"});
            run_op(d, OP_GEU, 32'h8000_0000, 32'h7FFF_FFFF, 4'd6, 1'b1, 1'b0, {p, "sign_geu"});
            run_op(d, OP_LTU, 32'h1234_0001, 32'h1234_0002, 4'd7, 1'b1, 1'b0, {p, "lo_ltu"});
            run_op(d, OP_EQ,  32'h1234_0001, 32'h1234_0002, 4'd8, 1'b0, 1'b0, {p, "lo_eq"});
            run_op(d, OP_LTU, 32'h0001_FFFF, 32'h0002_0000, 4'd9, 1'b1, 1'b0, {p, "hi_ltu"});
            run_op(d, OP_NE,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hC, 1'b0, 1'b0, {p, "ne_same"});
            stream(d, 1'b0, {p, "stream"});
            stream(d, 1'b1, {p, "stall"});
            run_op(d, 3'b010, 32'd5, 32'd5, 4'hA, 1'b0, 1'b1, {p, "illegal"});
            run_op(d, OP_EQ,  32'd5, 32'd5, 4'hB, 1'b1, 1'b0, {p, "after_illegal"});
            reset_flush(d, {p, "flush"});
            run_op(d, OP_GEU, 32'd3, 32'd7, 4'hE, 1'b0, 1'b0, {p, "after_reset"});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
